// File: rtl/id_operand_stage_pkg.sv
// id_operand_stage_pkg: shared widths for the ID operand stage
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef ID_CTRL_WIDTH
`define ID_CTRL_WIDTH 8
`endif
package id_operand_stage_pkg;
  localparam int XLEN_D   = `REG_WIDTH;
  localparam int RA_W_D   = `REG_ADDR_WIDTH;
  localparam int CTRL_W_D = `ID_CTRL_WIDTH;
  localparam int CNT_W_D  = 32;
endpackage

// File: rtl/id_operand_stage_operand_bypass_mux.sv
// operand_bypass_mux: picks x0, MEM, WB or register-file value for one source
module operand_bypass_mux
  import id_operand_stage_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int RA_W = RA_W_D
) (
  input  logic [RA_W-1:0] rs,
  input  logic [XLEN-1:0] rf_data,
  input  logic            mem_wen,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            mem_data_valid,
  input  logic            wb_wen,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] val
);
  always_comb begin
    val = (rs == '0) ? '0 :
          (mem_wen && mem_rd == rs && mem_data_valid) ? mem_data :
          (wb_wen && wb_rd == rs) ? wb_data : rf_data;
  end
endmodule

// File: rtl/id_operand_stage.sv
// id_operand_stage: resolves operands with MEM/WB bypass, stalls on load
// hazards and registers the result into the ID/EX register.
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int XLEN   = XLEN_D,
  parameter int RA_W   = RA_W_D,
  parameter int CTRL_W = CTRL_W_D,
  parameter int CNT_W  = CNT_W_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [RA_W-1:0]   in_rs1,
  input  logic [RA_W-1:0]   in_rs2,
  input  logic              in_use_rs1,
  input  logic              in_use_rs2,
  input  logic [RA_W-1:0]   in_rd,
  input  logic              in_rd_wen,
  input  logic              in_is_load,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [RA_W-1:0]   rf_r_addr1,
  output logic [RA_W-1:0]   rf_r_addr2,
  input  logic [XLEN-1:0]   rf_r_data1,
  input  logic [XLEN-1:0]   rf_r_data2,
  input  logic              mem_wen,
  input  logic [RA_W-1:0]   mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              mem_data_valid,
  input  logic              wb_wen,
  input  logic [RA_W-1:0]   wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_rs1_val,
  output logic [XLEN-1:0]   out_rs2_val,
  output logic [RA_W-1:0]   out_rd,
  output logic              out_rd_wen,
  output logic              out_is_load,
  output logic [XLEN-1:0]   out_imm,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            haz1, haz2, hazard;
  assign rf_r_addr1 = in_rs1;
  assign rf_r_addr2 = in_rs2;
  operand_bypass_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_mux1 (
    .rs(in_rs1), .rf_data(rf_r_data1), .mem_wen(mem_wen), .mem_rd(mem_rd),
    .mem_data(mem_data), .mem_data_valid(mem_data_valid), .wb_wen(wb_wen),
    .wb_rd(wb_rd), .wb_data(wb_data), .val(rs1_val)
  );
  operand_bypass_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_mux2 (
    .rs(in_rs2), .rf_data(rf_r_data2), .mem_wen(mem_wen), .mem_rd(mem_rd),
    .mem_data(mem_data), .mem_data_valid(mem_data_valid), .wb_wen(wb_wen),
    .wb_rd(wb_rd), .wb_data(wb_data), .val(rs2_val)
  );
  // load in ID/EX (load-use) or load still outstanding in MEM
  always_comb begin
    haz1 = in_use_rs1 && in_rs1 != '0 &&
           ((out_valid && out_is_load && out_rd_wen && out_rd == in_rs1) ||
            (mem_wen && !mem_data_valid && mem_rd == in_rs1));
    haz2 = in_use_rs2 && in_rs2 != '0 &&
           ((out_valid && out_is_load && out_rd_wen && out_rd == in_rs2) ||
            (mem_wen && !mem_data_valid && mem_rd == in_rs2));
    hazard   = in_valid && (haz1 || haz2);
    in_ready = !flush && !hazard && (!out_valid || out_ready);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
      out_rd      <= '0;
      out_rd_wen  <= 1'b0;
      out_is_load <= 1'b0;
      out_imm     <= '0;
      out_ctrl    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_rs1_val <= rs1_val;
      out_rs2_val <= rs2_val;
      out_rd      <= in_rd;
      out_rd_wen  <= in_rd_wen;
      out_is_load <= in_is_load;
      out_imm     <= in_imm;
      out_ctrl    <= in_ctrl;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= '0;
    else if (hazard && !flush && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage: directed vectors for bypass, hazards, handshake and flush
module tb_id_operand_stage;
  logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, in_ready;
  logic [31:0] in_pc = 0, in_imm = 0;
  logic [4:0]  in_rs1 = 0, in_rs2 = 0, in_rd = 0;
  logic        in_use_rs1 = 0, in_use_rs2 = 0, in_rd_wen = 0, in_is_load = 0;
  logic [7:0]  in_ctrl = 0;
  logic [4:0]  rf_r_addr1, rf_r_addr2;
  logic [31:0] rf_r_data1 = 0, rf_r_data2 = 0;
  logic        mem_wen = 0, mem_data_valid = 0, wb_wen = 0;
  logic [4:0]  mem_rd = 0, wb_rd = 0;
  logic [31:0] mem_data = 0, wb_data = 0;
  logic        out_valid, out_ready = 1, out_rd_wen, out_is_load;
  logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
  logic [4:0]  out_rd;
  logic [7:0]  out_ctrl;
  logic [3:0]  stall_cnt;
  int total = 0, bad = 0;

  id_operand_stage #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1),
    .in_use_rs2(in_use_rs2), .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_is_load(in_is_load),
    .in_imm(in_imm), .in_ctrl(in_ctrl), .rf_r_addr1(rf_r_addr1), .rf_r_addr2(rf_r_addr2),
    .rf_r_data1(rf_r_data1), .rf_r_data2(rf_r_data2), .mem_wen(mem_wen), .mem_rd(mem_rd),
    .mem_data(mem_data), .mem_data_valid(mem_data_valid), .wb_wen(wb_wen), .wb_rd(wb_rd),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_rd(out_rd),
    .out_rd_wen(out_rd_wen), .out_is_load(out_is_load), .out_imm(out_imm),
    .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic ld);
    in_valid = 1; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_wen = 1;
    in_is_load = ld; in_use_rs1 = 1; in_use_rs2 = 1; in_imm = pc + 7; in_ctrl = pc[7:0] ^ 8'h5a;
  endtask

  initial begin
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_pc", out_pc, 0);
    rst_n = 1;
    step();
    // 1: plain register-file operands
    instr(32'h100, 3, 4, 1, 0); rf_r_data1 = 32'h11; rf_r_data2 = 32'h22;
    #1;
    chk("rf_addr1", rf_r_addr1, 3);
    chk("rf_addr2", rf_r_addr2, 4);
    chk("t1_ready", in_ready, 1);
    step();
    chk("t1_valid", out_valid, 1);
    chk("t1_rs1", out_rs1_val, 32'h11);
    chk("t1_rs2", out_rs2_val, 32'h22);
    chk("t1_pc", out_pc, 32'h100);
    chk("t1_imm", out_imm, 32'h107);
    chk("t1_ctrl", out_ctrl, 8'h5a);
    // 2: forwarding priority
    instr(32'h104, 5, 4, 1, 0);
    wb_wen = 1; wb_rd = 5; wb_data = 32'hAA;
    mem_wen = 1; mem_rd = 5; mem_data = 32'hBB; mem_data_valid = 1;
    step();
    chk("t2_mem", out_rs1_val, 32'hBB);
    mem_wen = 0;
    step();
    chk("t2_wb", out_rs1_val, 32'hAA);
    in_rs1 = 0; mem_wen = 1; mem_rd = 0; wb_rd = 0;
    step();
    chk("t2_x0", out_rs1_val, 0);
    mem_wen = 0; wb_wen = 0;
    // 3: load-use costs one bubble then forwards from MEM
    instr(32'h108, 1, 2, 7, 1);
    step();
    chk("t3_ld_valid", out_valid, 1);
    instr(32'h10c, 0, 7, 8, 0);
    #1;
    chk("t3_ready0", in_ready, 0);
    step();
    chk("t3_bubble", out_valid, 0);
    chk("t3_cnt", stall_cnt, 1);
    mem_wen = 1; mem_rd = 7; mem_data_valid = 0; mem_data = 32'h5;
    #1;
    chk("t3_pending", in_ready, 0);
    mem_data_valid = 1;
    #1;
    chk("t3_ready1", in_ready, 1);
    step();
    chk("t3_valid", out_valid, 1);
    chk("t3_rs2", out_rs2_val, 32'h5);
    chk("t3_cnt2", stall_cnt, 1);
    mem_wen = 0;
    // 4: backpressure holds payload
    out_ready = 0;
    instr(32'h200, 3, 4, 9, 0); rf_r_data1 = 32'h33; rf_r_data2 = 32'h44;
    #1;
    chk("t4_ready0", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_hold_v", out_valid, 1);
      chk("t4_hold_pc", out_pc, 32'h10c);
      chk("t4_hold_rs2", out_rs2_val, 32'h5);
    end
    out_ready = 1;
    #1;
    chk("t4_ready1", in_ready, 1);
    step();
    chk("t4_pc", out_pc, 32'h200);
    chk("t4_rs1", out_rs1_val, 32'h33);
    chk("t4_cnt", stall_cnt, 1);
    // 5: flush
    instr(32'h300, 3, 4, 9, 0); flush = 1;
    #1;
    chk("t5_ready", in_ready, 0);
    step();
    chk("t5_valid", out_valid, 0);
    chk("t5_pc", out_pc, 32'h200);
    flush = 0;
    // 6: counter saturation, then async reset
    out_ready = 0;
    instr(32'h400, 0, 0, 9, 1);
    step();
    chk("t6_ld", out_valid, 1);
    instr(32'h404, 9, 0, 10, 0);
    for (int i = 0; i < 13; i++) step();
    chk("t6_cnt14", stall_cnt, 14);
    step();
    chk("t6_cnt15", stall_cnt, 15);
    for (int i = 0; i < 6; i++) step();
    chk("t6_sat", stall_cnt, 15);
    chk("t6_ready", in_ready, 0);
    #2;
    rst_n = 0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_cnt", stall_cnt, 0);
    chk("t6_rst_pc", out_pc, 0);
    chk("t6_rst_rd", out_rd, 0);
    chk("t6_rst_load", out_is_load, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
